// File: rtl/stack_pkg.sv
// Shared types for the stack core: opcodes, controller states and
// width helpers for the entry count and the RAM address.
package stack_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_PUSH = 4'd1,
      OP_POP  = 4'd2,
      OP_INC  = 4'd3,
      OP_DEC  = 4'd4,
      OP_ADD  = 4'd5,
      OP_DUP  = 4'd6,
      OP_SWAP = 4'd7
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int addr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/stack_if.sv
// Instruction handshake and stack status bundle between a master
// (instruction source) and the stack core.
interface stack_if
   import stack_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
);
   localparam int CW = cnt_width(DEPTH);

   logic              instr_valid;
   logic              instr_ready;
   logic [3:0]        instr_op;
   logic [DATA_W-1:0] instr_imm;
   logic              err_clr;
   logic [DATA_W-1:0] tos;
   logic              tos_valid;
   logic [CW-1:0]     count;
   logic              retire;
   logic              err_ovf;
   logic              err_unf;
   logic              err_ill;

   modport master (
      output instr_valid, instr_op, instr_imm, err_clr,
      input  instr_ready, tos, tos_valid, count, retire, err_ovf, err_unf, err_ill
   );

   modport slave (
      input  instr_valid, instr_op, instr_imm, err_clr,
      output instr_ready, tos, tos_valid, count, retire, err_ovf, err_unf, err_ill
   );
endinterface

// File: rtl/stack_ram.sv
// Storage for the entries below top-of-stack: one write port and one
// synchronous read port with a single cycle of latency, no reset.
module stack_ram
   import stack_pkg::*;
#(
   parameter int  DATA_W = 32,
   parameter int  DEPTH  = 256,
   localparam int AW     = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/stack_core.sv
// Stack machine core: top entry in a register, lower entries in stack_ram.
// Ops needing the next-on-stack take IDLE -> READ -> COMMIT; the rest finish at acceptance.
module stack_core
   import stack_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input logic     clk,
   input logic     rst_n,
   stack_if.slave  bus
);
   localparam int            CW   = cnt_width(DEPTH);
   localparam int            AW   = addr_width(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   state_e            state_q, state_d;
   opcode_e           op_q, op_d;
   logic [DATA_W-1:0] tos_q, tos_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ready_q, retire_q, retire_d;
   logic              ovf_q, unf_q, ill_q;
   logic              set_ovf, set_unf, set_ill;

   logic              ram_we, ram_re;
   logic [AW-1:0]     ram_waddr, ram_raddr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      tos_d     = tos_q;
      count_d   = count_q;
      retire_d  = 1'b0;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;
      set_ill   = 1'b0;
      ram_we    = 1'b0;
      ram_waddr = AW'(count_q - CW'(1));
      ram_wdata = tos_q;
      ram_re    = 1'b0;
      ram_raddr = AW'(count_q - CW'(2));

      unique case (state_q)
         ST_IDLE: begin
            if (bus.instr_valid && ready_q) begin
               retire_d = 1'b1;
               case (bus.instr_op)
                  OP_NOP: ;
                  OP_PUSH: begin
                     if (count_q == FULL) set_ovf = 1'b1;
                     else begin
                        ram_we  = (count_q != '0);
                        tos_d   = bus.instr_imm;
                        count_d = count_q + CW'(1);
                     end
                  end
                  OP_DUP: begin
                     if (count_q == '0) set_unf = 1'b1;
                     else if (count_q == FULL) set_ovf = 1'b1;
                     else begin
                        ram_we  = 1'b1;
                        count_d = count_q + CW'(1);
                     end
                  end
                  OP_INC, OP_DEC: begin
                     if (count_q == '0) set_unf = 1'b1;
                     else if (bus.instr_op == OP_INC) tos_d = tos_q + DATA_W'(1);
                     else tos_d = tos_q - DATA_W'(1);
                  end
                  OP_POP: begin
                     if (count_q == '0) set_unf = 1'b1;
                     else if (count_q == CW'(1)) begin
                        tos_d   = '0;
                        count_d = '0;
                     end else begin
                        state_d  = ST_READ;
                        op_d     = OP_POP;
                        retire_d = 1'b0;
                     end
                  end
                  OP_ADD, OP_SWAP: begin
                     if (count_q < CW'(2)) set_unf = 1'b1;
                     else begin
                        state_d  = ST_READ;
                        op_d     = opcode_e'(bus.instr_op);
                        retire_d = 1'b0;
                     end
                  end
                  default: set_ill = 1'b1;
               endcase
            end
         end
         ST_READ: begin
            ram_re  = 1'b1;
            state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            // Top value and count move together here, never one before the other.
            state_d  = ST_IDLE;
            retire_d = 1'b1;
            case (op_q)
               OP_ADD: begin
                  tos_d   = tos_q + ram_rdata;
                  count_d = count_q - CW'(1);
               end
               OP_SWAP: begin
                  tos_d     = ram_rdata;
                  ram_we    = 1'b1;
                  ram_waddr = AW'(count_q - CW'(2));
               end
               default: begin
                  tos_d   = ram_rdata;
                  count_d = count_q - CW'(1);
               end
            endcase
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_NOP;
         tos_q    <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
         retire_q <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         tos_q    <= tos_d;
         count_q  <= count_d;
         ready_q  <= (state_d == ST_IDLE);
         retire_q <= retire_d;
         // A fault raised alongside err_clr still leaves its flag set.
         ovf_q    <= (ovf_q & ~bus.err_clr) | set_ovf;
         unf_q    <= (unf_q & ~bus.err_clr) | set_unf;
         ill_q    <= (ill_q & ~bus.err_clr) | set_ill;
      end
   end

   assign bus.instr_ready = ready_q;
   assign bus.tos         = tos_q;
   assign bus.tos_valid   = (count_q != '0);
   assign bus.count       = count_q;
   assign bus.retire      = retire_q;
   assign bus.err_ovf     = ovf_q;
   assign bus.err_unf     = unf_q;
   assign bus.err_ill     = ill_q;
endmodule

// File: tb/tb_stack_core.sv
// Self-checking bench for stack_core: directed scenarios plus a random
// instruction stream compared against a queue-based stack model.
module tb_stack_core;
   import stack_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = cnt_width(DEPTH);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stack_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

   stack_core #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors     = 0;
   int checks     = 0;
   int retire_cnt = 0;

   always @(posedge clk) if (bus.retire) retire_cnt <= retire_cnt + 1;

   logic [DW-1:0] mstk [$];
   bit m_ovf, m_unf, m_ill;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference stack: queue back is top-of-stack.
   task automatic model_apply(input logic [3:0] op, input logic [DW-1:0] imm,
                              input bit clr, output bit multi);
      bit fo, fu, fi;
      int n;
      logic [DW-1:0] a, b;
      fo = 0; fu = 0; fi = 0; multi = 0;
      n = mstk.size();
      case (op)
         4'd0: ;
         4'd1: if (n >= DEPTH) fo = 1; else mstk.push_back(imm);
         4'd2: if (n < 1) fu = 1; else begin a = mstk.pop_back(); multi = (n >= 2); end
         4'd3: if (n < 1) fu = 1; else mstk[n-1] = mstk[n-1] + 1;
         4'd4: if (n < 1) fu = 1; else mstk[n-1] = mstk[n-1] - 1;
         4'd5: if (n < 2) fu = 1;
               else begin a = mstk.pop_back(); b = mstk.pop_back(); mstk.push_back(a + b); multi = 1; end
         4'd6: if (n < 1) fu = 1; else if (n >= DEPTH) fo = 1; else mstk.push_back(mstk[n-1]);
         4'd7: if (n < 2) fu = 1;
               else begin a = mstk[n-1]; mstk[n-1] = mstk[n-2]; mstk[n-2] = a; multi = 1; end
         default: fi = 1;
      endcase
      if (clr) begin m_ovf = 0; m_unf = 0; m_ill = 0; end
      m_ovf |= fo; m_unf |= fu; m_ill |= fi;
   endtask

   task automatic check_state(input string tag);
      logic [DW-1:0] et;
      et = (mstk.size() > 0) ? mstk[mstk.size()-1] : '0;
      check_eq({tag, ".tos"},   bus.tos, et);
      check_eq({tag, ".count"}, bus.count, mstk.size());
      check_eq({tag, ".tosv"},  bus.tos_valid, mstk.size() > 0);
      check_eq({tag, ".ovf"},   bus.err_ovf, m_ovf);
      check_eq({tag, ".unf"},   bus.err_unf, m_unf);
      check_eq({tag, ".ill"},   bus.err_ill, m_ill);
   endtask

   task automatic issue(input logic [3:0] op, input logic [DW-1:0] imm, input bit clr);
      int w, lowcnt;
      bit multi;
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr_op    = op;
      bus.instr_imm   = imm;
      bus.err_clr     = clr;
      w = 0;
      while (!bus.instr_ready && w < 20) begin @(negedge clk); w++; end
      if (!bus.instr_ready) begin
         check_eq("accept", bus.instr_ready, 1);
         bus.instr_valid = 1'b0; bus.err_clr = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.err_clr     = 1'b0;
      bus.instr_op    = 4'($urandom);
      bus.instr_imm   = $urandom;
      model_apply(op, imm, clr, multi);
      w = 0; lowcnt = 0;
      do begin
         @(negedge clk);
         w++;
         if (!bus.instr_ready) lowcnt++;
      end while (!bus.retire && w < 10);
      check_eq($sformatf("latency.op%0d", op), w, multi ? 3 : 1);
      check_eq($sformatf("busy.op%0d", op), lowcnt, multi ? 2 : 0);
      check_state($sformatf("op%0d", op));
      $display("instr op=%0d imm=%0h clr=%0d -> tos=%0h count=%0d ovf=%0d unf=%0d ill=%0d",
               op, imm, clr, bus.tos, bus.count, bus.err_ovf, bus.err_unf, bus.err_ill);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst.ready", bus.instr_ready, 0);
      check_eq("rst.tos", bus.tos, 0);
      check_eq("rst.count", bus.count, 0);
      check_eq("rst.retire", bus.retire, 0);
      check_eq("rst.flags", {bus.err_ovf, bus.err_unf, bus.err_ill}, 0);
      mstk.delete();
      m_ovf = 0; m_unf = 0; m_ill = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst.ready_rise", bus.instr_ready, 1);
   endtask

   initial begin
      int base;
      logic [3:0] op;
      logic [DW-1:0] imm;
      int r;
      bus.instr_valid = 1'b0;
      bus.instr_op    = 4'd0;
      bus.instr_imm   = '0;
      bus.err_clr     = 1'b0;
      #1;
      check_eq("por.ready", bus.instr_ready, 0);
      check_eq("por.count", bus.count, 0);

      // Two pushes and an add; three retire pulses.
      do_reset();
      base = retire_cnt;
      issue(4'd1, 32'd5, 0);
      issue(4'd1, 32'd7, 0);
      issue(4'd5, 32'd0, 0);
      @(negedge clk);
      check_eq("add.tos12", bus.tos, 12);
      check_eq("add.count1", bus.count, 1);
      check_eq("add.retires", retire_cnt - base, 3);

      // Silent wrap on INC/DEC.
      do_reset();
      issue(4'd1, 32'hFFFF_FFFF, 0);
      issue(4'd3, 32'd0, 0);
      check_eq("inc.wrap", bus.tos, 0);
      check_eq("inc.noflag", {bus.err_ovf, bus.err_unf, bus.err_ill}, 0);
      issue(4'd4, 32'd0, 0);
      check_eq("dec.wrap", bus.tos, 32'hFFFF_FFFF);

      // SWAP/POP, then underflow on an empty stack.
      do_reset();
      issue(4'd1, 32'd1, 0);
      issue(4'd1, 32'd2, 0);
      issue(4'd7, 32'd0, 0);
      issue(4'd2, 32'd0, 0);
      check_eq("swap.tos2", bus.tos, 2);
      check_eq("swap.count1", bus.count, 1);
      issue(4'd2, 32'd0, 0);
      issue(4'd2, 32'd0, 0);
      check_eq("pop.unf", bus.err_unf, 1);
      check_eq("pop.tosv", bus.tos_valid, 0);

      // Full stack, overflow, illegal op, clear racing a new overflow.
      do_reset();
      for (int i = 0; i < DEPTH; i++) issue(4'd1, 32'(i + 100), 0);
      issue(4'd1, 32'd9, 0);
      check_eq("full.ovf", bus.err_ovf, 1);
      check_eq("full.count", bus.count, DEPTH);
      check_eq("full.tos", bus.tos, 32'd103);
      issue(4'd12, 32'd0, 0);
      check_eq("ill.set", bus.err_ill, 1);
      issue(4'd1, 32'd10, 1);
      check_eq("clr.ovf_wins", bus.err_ovf, 1);
      check_eq("clr.ill_clear", bus.err_ill, 0);

      // Reset while ADD sits in COMMIT.
      do_reset();
      issue(4'd1, 32'd3, 0);
      issue(4'd1, 32'd4, 0);
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr_op    = 4'd5;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      @(posedge clk);
      #2;
      check_eq("commit.busy", bus.instr_ready, 0);
      rst_n = 1'b0;
      #1;
      check_eq("abort.count", bus.count, 0);
      check_eq("abort.tos", bus.tos, 0);
      check_eq("abort.flags", {bus.err_ovf, bus.err_unf, bus.err_ill}, 0);
      mstk.delete();
      m_ovf = 0; m_unf = 0; m_ill = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(4'd1, 32'd6, 0);
      check_eq("abort.push6", bus.tos, 6);
      check_eq("abort.count1", bus.count, 1);

      // Random stream with idle gaps and occasional clears.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         r = $urandom_range(0, 19);
         if (r < 2)      op = 4'($urandom_range(8, 15));
         else if (r < 7) op = 4'd1;
         else            op = 4'($urandom_range(0, 7));
         r = $urandom_range(0, 9);
         imm = (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'd0 : DW'($urandom);
         issue(op, imm, $urandom_range(0, 9) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
